uart_alu_ctrl: RTL and testbench

- Packet sequencer between the uart_rx AXI-Stream master and the uart_tx AXI-Stream slave in uart_alu.
- Replaces the direct rx→tx loopback: parses framed command packets, performs echo/add/multiply, and streams results to the host.
- Single clock domain; byte-wide streams on both sides.

---
 rtl/uart_alu_ctrl_if.sv | 27 ++
 rtl/uart_alu_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_ctrl_if.sv
// uart_alu_ctrl_if: byte streams between uart_rx, the packet sequencer and
// uart_tx.
//   rx_data_i / rx_valid_i / rx_ready_o : uart_rx m_axis -> sequencer
//   tx_data_o / tx_valid_o / tx_ready_i : sequencer -> uart_tx s_axis
// The suffixes are written from the sequencer's point of view.
//   slave  modport: the sequencer side.
//   master modport: the side that drives rx and sinks tx.
interface uart_alu_ctrl_if #(
    parameter int DW = 8
);
    logic [DW-1:0] rx_data_i;
    logic          rx_valid_i;
    logic          rx_ready_o;
    logic [DW-1:0] tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready_i;

    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i,
        output rx_ready_o, tx_data_o, tx_valid_o
    );

    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i,
        input  rx_ready_o, tx_data_o, tx_valid_o
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: parses framed command packets from uart_rx and streams
// results to uart_tx.
// Packet layout: opcode, reserved, LEN lo, LEN hi, then LEN-4 payload bytes.
// Opcodes: 0xEC echo, 0xA5 add, 0xB6 multiply.
// Ports:
//   clk_i, rst_i : clock and asynchronous active-high reset
//   bus          : rx/tx byte streams (slave modport)
//   busy_o       : high while a packet is in progress
//   err_o        : one-cycle pulse when a header is malformed
module uart_alu_ctrl #(
    parameter int datawidth_p = 8,
    parameter int opwidth_p   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    uart_alu_ctrl_if.slave        bus,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int NB = opwidth_p / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_B = CW'(NB - 1);
    localparam logic [15:0]   NB16   = 16'(NB);

    typedef enum logic [2:0] {
        S_OP, S_RSV, S_LENL, S_LENH, S_ECHO, S_OPND, S_RES, S_DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             op_q, op_d;
    logic [7:0]             lenl_q, lenl_d;
    logic [15:0]            rem_q, rem_d;
    logic [opwidth_p-1:0]   sh_q, sh_d;
    logic [opwidth_p-1:0]   acc_q, acc_d;
    logic [CW-1:0]          bcnt_q, bcnt_d;
    logic [CW-1:0]          ocnt_q, ocnt_d;
    logic                   first_q, first_d;
    logic                   err_q, err_d;
    // Holds rx_ready_o low until the first edge after reset release.
    logic                   rdy_q;

    logic [datawidth_p-1:0] tx_dat;
    logic                   tx_vld, rx_rdy;
    logic [15:0]            len, pay;
    logic [opwidth_p+7:0]   cat;
    logic [opwidth_p-1:0]   word;
    logic                   is_echo, is_add, is_mul;

    assign len     = {bus.rx_data_i, lenl_q};
    assign pay     = len - 16'd4;
    // New byte enters at the top so the word ends up little-endian.
    assign cat     = {bus.rx_data_i, sh_q};
    assign word    = cat[opwidth_p+7:8];
    assign is_echo = (op_q == 8'hEC);
    assign is_add  = (op_q == 8'hA5);
    assign is_mul  = (op_q == 8'hB6);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_OP;
            op_q    <= '0;
            lenl_q  <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            bcnt_q  <= '0;
            ocnt_q  <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lenl_q  <= lenl_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            bcnt_q  <= bcnt_d;
            ocnt_q  <= ocnt_d;
            first_q <= first_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lenl_d  = lenl_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        bcnt_d  = bcnt_q;
        ocnt_d  = ocnt_q;
        first_d = first_q;
        err_d   = 1'b0;
        rx_rdy  = 1'b0;
        tx_vld  = 1'b0;
        // Result bytes come straight from the shifting accumulator register.
        tx_dat  = acc_q[7:0];
        case (state_q)
            S_OP: begin
                rx_rdy = rdy_q;
                if (bus.rx_valid_i && rdy_q) begin
                    op_d    = bus.rx_data_i;
                    state_d = S_RSV;
                end
            end
            S_RSV: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i) state_d = S_LENL;
            end
            S_LENL: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i) begin
                    lenl_d  = bus.rx_data_i;
                    state_d = S_LENH;
                end
            end
            S_LENH: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i) begin
                    rem_d   = pay;
                    bcnt_d  = '0;
                    ocnt_d  = '0;
                    sh_d    = '0;
                    first_d = 1'b1;
                    if (len < 16'd4) begin
                        err_d   = 1'b1;
                        state_d = S_OP;
                    end else if (!is_echo && !is_add && !is_mul) begin
                        err_d   = 1'b1;
                        state_d = (pay == 16'd0) ? S_OP : S_DRAIN;
                    end else if (is_echo) begin
                        state_d = (pay == 16'd0) ? S_OP : S_ECHO;
                    end else if (pay == 16'd0 || (pay % NB16) != 16'd0) begin
                        err_d   = 1'b1;
                        state_d = (pay == 16'd0) ? S_OP : S_DRAIN;
                    end else begin
                        state_d = S_OPND;
                    end
                end
            end
            S_ECHO: begin
                tx_dat = bus.rx_data_i;
                tx_vld = bus.rx_valid_i;
                rx_rdy = bus.tx_ready_i;
                if (bus.rx_valid_i && bus.tx_ready_i) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_OP;
                end
            end
            S_OPND: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i) begin
                    rem_d = rem_q - 16'd1;
                    sh_d  = word;
                    if (bcnt_q == LAST_B) begin
                        bcnt_d  = '0;
                        first_d = 1'b0;
                        if (first_q)     acc_d = word;
                        else if (is_mul) acc_d = acc_q * word;
                        else             acc_d = acc_q + word;
                    end else begin
                        bcnt_d = bcnt_q + CW'(1);
                    end
                    if (rem_q == 16'd1) state_d = S_RES;
                end
            end
            S_RES: begin
                tx_vld = 1'b1;
                if (bus.tx_ready_i) begin
                    acc_d  = acc_q >> 8;
                    ocnt_d = ocnt_q + CW'(1);
                    if (ocnt_q == LAST_B) state_d = S_OP;
                end
            end
            S_DRAIN: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_OP;
                end
            end
            default: state_d = S_OP;
        endcase
    end

    assign bus.rx_ready_o = rx_rdy;
    assign bus.tx_valid_o = tx_vld;
    assign bus.tx_data_o  = tx_dat;
    assign busy_o         = (state_q != S_OP);
    assign err_o          = err_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: directed packets, a packet-level reference
// model checked every cycle, and literal expectations per packet.
module tb_uart_alu_ctrl;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic busy_o, err_o;

    always #5 clk = ~clk;

    uart_alu_ctrl_if #(.DW(8)) bus();

    uart_alu_ctrl #(.datawidth_p(8), .opwidth_p(32)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus),
        .busy_o(busy_o),
        .err_o (err_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    int          m_idx, m_len, m_left, m_k, res_pend, err_cnt;
    logic [7:0]  m_op;
    bit          m_echo, m_opnd, m_mul, m_first, err_pend;
    logic [63:0] m_acc, m_w;
    logic [7:0]  expq[$];
    logic [7:0]  got[$];

    task automatic model_clear();
        m_idx = 0; m_len = 0; m_left = 0; m_k = 0; res_pend = 0;
        m_echo = 0; m_opnd = 0; m_mul = 0; m_first = 0; err_pend = 0;
        m_acc = 0; m_w = 0; m_op = 0;
        expq.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_idx)
            0: begin m_op = b; m_idx = 1; end
            1: m_idx = 2;
            2: begin m_len = int'(b); m_idx = 3; end
            3: begin
                m_len = m_len + int'(b) * 256;
                m_echo = 0; m_opnd = 0; m_first = 1; m_k = 0; m_w = 0; m_acc = 0;
                if (m_len < 4) begin
                    err_pend = 1;
                    m_idx = 0;
                end else begin
                    m_left = m_len - 4;
                    if (m_op == 8'hEC) m_echo = 1;
                    else if (m_op == 8'hA5 || m_op == 8'hB6) begin
                        if (m_left == 0 || m_left % 4 != 0) err_pend = 1;
                        else begin m_opnd = 1; m_mul = (m_op == 8'hB6); end
                    end else err_pend = 1;
                    m_idx = (m_left == 0) ? 0 : 4;
                end
            end
            default: begin
                m_left--;
                if (m_echo) expq.push_back(b);
                if (m_opnd) begin
                    m_w = m_w | (64'(b) << (8 * m_k));
                    m_k++;
                    if (m_k == 4) begin
                        if (m_first)    m_acc = m_w;
                        else if (m_mul) m_acc = (m_acc * m_w) & 64'hFFFF_FFFF;
                        else            m_acc = (m_acc + m_w) & 64'hFFFF_FFFF;
                        m_first = 0; m_k = 0; m_w = 0;
                    end
                end
                if (m_left == 0) begin
                    m_idx = 0;
                    if (m_opnd) begin
                        for (int i = 0; i < 4; i++) expq.push_back(8'((m_acc >> (8 * i)) & 64'hFF));
                        res_pend = 4;
                    end
                end
            end
        endcase
    endtask

    // Single compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_i) begin
            model_clear();
        end else begin
            chk("busy", busy_o, (m_idx > 0 || res_pend > 0) ? 32'd1 : 32'd0);
            chk("err", err_o, 32'(err_pend));
            if (err_o) err_cnt++;
            if (res_pend > 0) chk("rx_ready_in_res", bus.rx_ready_o, 32'd0);
            err_pend = 0;
            if (bus.rx_valid_i && bus.rx_ready_o) model_byte(bus.rx_data_i);
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                got.push_back(bus.tx_data_o);
                chk("tx_expected", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) chk("tx_data", bus.tx_data_o, expq.pop_front());
                if (res_pend > 0) res_pend--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        bit ok;
        n = 0; ok = 0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (bus.rx_ready_o) ok = 1;
            @(posedge clk); #1;
            n++;
        end
        chk("rx_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_pkt(input logic [7:0] p[$]);
        foreach (p[i]) send_byte(p[i]);
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!busy_o && expq.size() == 0) done = 1;
        end
        @(posedge clk); #1;
        chk("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic chk_got(input string nm, input logic [7:0] exp[$]);
        chk({nm, "_count"}, got.size(), exp.size());
        foreach (exp[i])
            if (i < got.size()) chk(nm, got[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] pk[$];
    logic [7:0] ex[$];
    int e0;

    initial begin
        err_cnt = 0;
        bus.rx_data_i  = 8'h00;
        bus.rx_valid_i = 1'b0;
        bus.tx_ready_i = 1'b1;
        model_clear();
        #2 rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_tx_valid", bus.tx_valid_o, 0);
        chk("rst_tx_data", bus.tx_data_o, 0);
        chk("rst_rx_ready", bus.rx_ready_o, 0);
        @(negedge clk); #2 rst_i = 1'b0;
        #1 chk("rx_ready_before_edge", bus.rx_ready_o, 0);
        @(posedge clk); #1;
        chk("rx_ready_after_edge", bus.rx_ready_o, 1);

        // Echo
        got.delete(); e0 = err_cnt;
        pk = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42};
        send_pkt(pk);
        chk("echo_busy_mid", busy_o, 1);
        send_byte(8'h43); bus.rx_valid_i = 1'b0;
        chk("echo_busy_fall", busy_o, 0);
        ex = '{8'h41, 8'h42, 8'h43}; chk_got("echo", ex);
        wait_idle();
        chk("echo_noerr", err_cnt - e0, 0);

        // Add
        got.delete();
        pk = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(pk); wait_idle();
        ex = '{8'h03, 8'h00, 8'h00, 8'h00}; chk_got("add", ex);

        // Multiply wrap
        got.delete();
        pk = '{8'hB6, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        send_pkt(pk); wait_idle();
        ex = '{8'h00, 8'h00, 8'h00, 8'h00}; chk_got("mul_wrap", ex);

        // Multiply, small
        got.delete();
        pk = '{8'hB6, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        send_pkt(pk); wait_idle();
        ex = '{8'h0F, 8'h00, 8'h00, 8'h00}; chk_got("mul", ex);

        // Add wrap
        got.delete();
        pk = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(pk); wait_idle();
        ex = '{8'h01, 8'h00, 8'h00, 8'h00}; chk_got("add_wrap", ex);

        // Three-operand add
        got.delete();
        pk = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
               8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        send_pkt(pk); wait_idle();
        ex = '{8'h06, 8'h00, 8'h00, 8'h00}; chk_got("add3", ex);

        // Invalid opcode, drained, followed by a good echo
        got.delete(); e0 = err_cnt;
        pk = '{8'h11, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt(pk); wait_idle();
        chk("badop_err", err_cnt - e0, 1);
        chk("badop_notx", got.size(), 0);
        pk = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_pkt(pk); wait_idle();
        ex = '{8'h5A}; chk_got("echo_after_err", ex);

        // Payload not a word multiple
        got.delete(); e0 = err_cnt;
        pk = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        send_pkt(pk); wait_idle();
        chk("badlen_err", err_cnt - e0, 1);
        chk("badlen_notx", got.size(), 0);

        // LEN < 4
        e0 = err_cnt;
        pk = '{8'hA5, 8'h00, 8'h02, 8'h00};
        send_pkt(pk);
        chk("shortlen_idle", busy_o, 0);
        chk("shortlen_pulse", err_o, 1);
        @(posedge clk); #1;
        chk("shortlen_pulse_end", err_o, 0);
        chk("shortlen_err", err_cnt - e0, 1);

        // Backpressure on the result
        got.delete();
        pk = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00};
        send_pkt(pk);
        bus.tx_ready_i = 1'b0;
        send_byte(8'h00); bus.rx_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.tx_valid_o, 1);
            chk("bp_data", bus.tx_data_o, 32'h78);
            chk("bp_rx_ready", bus.rx_ready_o, 0);
        end
        @(posedge clk); #1 bus.tx_ready_i = 1'b1;
        wait_idle();
        ex = '{8'h78, 8'h56, 8'h34, 8'h12}; chk_got("bp", ex);

        // Asynchronous reset between operand bytes
        pk = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
        send_pkt(pk);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_rx_ready", bus.rx_ready_o, 0);
        chk("arst_tx_valid", bus.tx_valid_o, 0);
        chk("arst_err", err_o, 0);
        @(negedge clk); #2 rst_i = 1'b0;
        @(posedge clk); #1;
        got.delete();
        pk = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt(pk); wait_idle();
        ex = '{8'h0C, 8'h00, 8'h00, 8'h00}; chk_got("post_reset_add", ex);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
